// File: rtl/expr_vector_sequencer_if.sv
// Operand/result and control bundle between the vector sequencer
// and whatever drives it (host side) and the datapath it exercises.
interface expr_vector_sequencer_if #(
    parameter int OPW  = 60,
    parameter int RESW = 90,
    parameter int CNTW = 16
);
    logic            start;
    logic            abort;
    logic [OPW-1:0]  seed;
    logic [CNTW-1:0] num_vec;
    logic [RESW-1:0] exp_sig;
    logic [OPW-1:0]  stim;
    logic            stim_valid;
    logic [RESW-1:0] res;
    logic            busy;
    logic            done;
    logic            pass;
    logic [RESW-1:0] signature;
    logic [CNTW-1:0] vec_idx;

    modport master (
        output start, abort, seed, num_vec, exp_sig, res,
        input  stim, stim_valid, busy, done, pass, signature, vec_idx
    );

    modport slave (
        input  start, abort, seed, num_vec, exp_sig, res,
        output stim, stim_valid, busy, done, pass, signature, vec_idx
    );
endinterface

// File: rtl/expr_vector_sequencer.sv
// LFSR stimulus generator and MISR signature compactor that drives a
// combinational expression datapath and checks its final signature.
module expr_vector_sequencer #(
    parameter int OPW  = 60,
    parameter int RESW = 90,
    parameter int LAT  = 1,
    parameter int CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    expr_vector_sequencer_if.slave bus_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_e;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_e          state_q, state_d;
    logic [OPW-1:0]  stim_q, stim_d;
    logic [RESW-1:0] sig_q, sig_d;
    logic [CNTW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [3:0]      wait_q, wait_d;
    logic            fb;
    logic            busy;

    // State and datapath registers, all cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            sig_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: run control, LFSR advance and MISR fold
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        fb      = sig_q[RESW-1] ^ sig_q[RESW-3]
                ^ sig_q[54] ^ sig_q[35];
        if (bus_if.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus_if.start) begin
                        stim_d = (bus_if.seed == '0)
                               ? {{(OPW-1){1'b0}}, 1'b1}
                               : bus_if.seed;
                        sig_d  = '0;
                        idx_d  = '0;
                        rem_d  = bus_if.num_vec;
                        state_d = (bus_if.num_vec == '0)
                                ? S_DONE : S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_d  = LAT_C;
                    state_d = (LAT_C != 4'd0) ? S_WAIT : S_CAPT;
                end
                S_WAIT: begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        state_d = S_CAPT;
                    end
                end
                S_CAPT: begin
                    sig_d  = {sig_q[RESW-2:0], fb} ^ bus_if.res;
                    idx_d  = idx_q + CNTW'(1);
                    rem_d  = rem_q - CNTW'(1);
                    stim_d = {stim_q[OPW-2:0],
                              stim_q[OPW-1] ^ stim_q[OPW-2]};
                    state_d = (rem_q == CNTW'(1)) ? S_DONE : S_DRIVE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_DRIVE)
               || (state_q == S_WAIT)
               || (state_q == S_CAPT);

    assign bus_if.stim       = stim_q;
    assign bus_if.stim_valid = busy;
    assign bus_if.busy       = busy;
    assign bus_if.done       = (state_q == S_DONE);
    assign bus_if.pass       = (state_q == S_DONE)
                            && (sig_q == bus_if.exp_sig);
    assign bus_if.signature  = sig_q;
    assign bus_if.vec_idx    = idx_q;

endmodule
